// File: rtl/mem_rr_arbiter_pkg.sv
// Shared types and default sizing for the round-robin memory arbiter.
package mem_arb_pkg;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_ADDR_WIDTH  = 6;
  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_TIMEOUT_CYC = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_rr_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr_i, wrapping.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic                       any_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NUM_REQ);

  logic [IDW:0]   sum;
  logic [IDW-1:0] cand;

  always_comb begin
    // NOTE: every output and temporary gets a value before the loop, so no path leaves one unassigned (no latch).
    any_o = 1'b0;
    idx_o = '0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr_i} + (IDW+1)'(i);
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      cand = sum[IDW-1:0];
      if (!any_o && req_i[cand]) begin
        any_o = 1'b1;
        idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port memory between NUM_REQ requesters.
// Optional BUSY watchdog with timeout_o port: define MEM_ARB_TIMEOUT_EN.
module mem_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_wr_rd_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [DATA_WIDTH-1:0]         req_rdata_o,
  output logic [$clog2(NUM_REQ)-1:0]    gnt_id_o,
  output logic                          busy_o,
`ifdef MEM_ARB_TIMEOUT_EN
  output logic                          timeout_o,
`endif
  output logic                          mem_valid_o,
  output logic                          mem_wr_rd_o,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  output logic [DATA_WIDTH-1:0]         mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]         mem_rdata_i,
  input  logic                          mem_ready_i
);

  localparam int IDW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("mem_rr_arbiter: unsupported parameter set");
  end

  arb_state_t              state_q, state_d;
  logic [IDW-1:0]          ptr_q, ptr_d;
  logic [IDW-1:0]          gnt_q, gnt_d;
  logic                    mem_valid_q, mem_valid_d;
  logic                    mem_wr_rd_q, mem_wr_rd_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [NUM_REQ-1:0]      ready_q, ready_d;
  logic                    pick_any;
  logic [IDW-1:0]          pick_idx;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int              CNTW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT_CYC - 1);
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
`endif

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    mem_valid_d = mem_valid_q;
    mem_wr_rd_d = mem_wr_rd_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    ready_d     = '0;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    timeout_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d       = pick_idx;
          mem_valid_d = 1'b1;
          mem_wr_rd_d = req_wr_rd_i[pick_idx];
          mem_addr_d  = req_addr_i[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
          mem_wdata_d = req_wdata_i[pick_idx*DATA_WIDTH +: DATA_WIDTH];
          state_d     = BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      BUSY: begin
        if (mem_ready_i) begin
          mem_valid_d    = 1'b0;
          if (!mem_wr_rd_q) rdata_d = mem_rdata_i;
          ready_d[gnt_q] = 1'b1;
          state_d        = DONE;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          mem_valid_d    = 1'b0;
          rdata_d        = '0;
          ready_d[gnt_q] = 1'b1;
          timeout_d      = 1'b1;
          state_d        = DONE;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
`endif
      end
      DONE: begin
        // Rotate past the grantee so any other pending requester wins next.
        ptr_d   = (gnt_q == IDW'(NUM_REQ - 1)) ? '0 : gnt_q + IDW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the latched request fields are reset too, since every output must read zero out of reset.
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      mem_valid_q <= 1'b0;
      mem_wr_rd_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      ready_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      mem_valid_q <= mem_valid_d;
      mem_wr_rd_q <= mem_wr_rd_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`endif

  assign req_ready_o = ready_q;
  assign req_rdata_o = rdata_q;
  assign gnt_id_o    = gnt_q;
  assign busy_o      = (state_q != IDLE);
  assign mem_valid_o = mem_valid_q;
  assign mem_wr_rd_o = mem_wr_rd_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Self-checking bench for mem_rr_arbiter: vector table, directed corner cases and a randomized run against a transaction-level model.
module tb_mem_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 6;
  localparam int DW = 16;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic [N-1:0]    v  = '0;
  logic [N-1:0]    wr = '0;
  logic [AW-1:0]   a  [N];
  logic [DW-1:0]   wd [N];
  logic [N*AW-1:0] req_addr_i;
  logic [N*DW-1:0] req_wdata_i;
  logic [N-1:0]    req_ready_o;
  logic [DW-1:0]   req_rdata_o;
  logic [1:0]      gnt_id_o;
  logic            busy_o;
  logic            mem_valid_o, mem_wr_rd_o;
  logic [AW-1:0]   mem_addr_o;
  logic [DW-1:0]   mem_wdata_o;
  logic [DW-1:0]   mem_rdata_i = '0;
  logic            mem_ready_i = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
  logic            timeout_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  always_comb begin
    req_addr_i  = '0;
    req_wdata_i = '0;
    for (int k = 0; k < N; k++) begin
      req_addr_i[k*AW +: AW]  = a[k];
      req_wdata_i[k*DW +: DW] = wd[k];
    end
  end

  mem_rr_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYC(16)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (v),
    .req_wr_rd_i (wr),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .req_ready_o (req_ready_o),
    .req_rdata_o (req_rdata_o),
    .gnt_id_o    (gnt_id_o),
    .busy_o      (busy_o),
`ifdef MEM_ARB_TIMEOUT_EN
    .timeout_o   (timeout_o),
`endif
    .mem_valid_o (mem_valid_o),
    .mem_wr_rd_o (mem_wr_rd_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ready_i (mem_ready_i)
  );

  // Memory responder: answers bfm_lat cycles after seeing a new request.
  logic [DW-1:0] bfm_mem [64];
  int bfm_lat = 0;
  int bfm_cnt = 0;
  bit bfm_active = 0;
  bit bfm_stall = 0;
  bit bfm_force_ready = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bfm_step();
    mem_ready_i = bfm_force_ready;
    mem_rdata_i = '0;
    if (!mem_valid_o || rst_i) begin
      bfm_active = 0;
    end else if (!bfm_stall) begin
      if (!bfm_active) begin
        bfm_active = 1;
        bfm_cnt    = bfm_lat;
      end
      if (bfm_cnt == 0) begin
        mem_ready_i = 1'b1;
        if (mem_wr_rd_o) bfm_mem[mem_addr_o] = mem_wdata_o;
        else             mem_rdata_i = bfm_mem[mem_addr_o];
        bfm_active = 0;
      end else begin
        bfm_cnt--;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk_i);
    #1;
    bfm_step();
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    v     = '0;
    cycle();
    cycle();
    rst_i = 1'b0;
  endtask

  task automatic wait_ready(input string name, input int max);
    bit ok;
    ok = 0;
    for (int c = 0; c < max && !ok; c++) begin
      cycle();
      if (req_ready_o != '0) ok = 1;
    end
    check({name, "_wait"}, 32'(ok), 32'd1);
  endtask

  function automatic int rr_ref(input logic [N-1:0] vv, input int p);
    for (int i = 0; i < N; i++) begin
      int k;
      k = (p + i) % N;
      if (vv[k]) return k;
    end
    return -1;
  endfunction

  task automatic new_req(input int k, input bit en);
    v[k]  = en;
    wr[k] = 1'($urandom % 2);
    a[k]  = 6'($urandom_range(0, 15));
    wd[k] = 16'($urandom);
  endtask

  typedef struct {
    logic [N-1:0] valid;
    logic         wr;
    int           exp_gnt;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t tbl [11];

  task automatic run_entry(input vec_t e, input int idx);
    bit seen, ok;
    for (int k = 0; k < N; k++) begin
      a[k]  = 6'(8 + k);
      wd[k] = 16'((idx + 1) * 256 + k);
    end
    wr = e.wr ? '1 : '0;
    v  = e.valid;
    seen = 0;
    ok   = 0;
    for (int c = 0; c < 20 && !ok; c++) begin
      cycle();
      if (mem_valid_o && !seen) begin
        seen = 1;
        check("tbl_mem_addr", 32'(mem_addr_o), 32'(8 + e.exp_gnt));
      end
      if (req_ready_o != '0) ok = 1;
    end
    check("tbl_wait", 32'(ok), 32'd1);
    check("tbl_ready", 32'(req_ready_o), 32'(1 << e.exp_gnt));
    check("tbl_gnt_id", 32'(gnt_id_o), 32'(e.exp_gnt));
    check("tbl_rdata", 32'(req_rdata_o), 32'(e.exp_rdata));
    v = '0;
    cycle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] ref_mem [64];
    int ref_ptr, inf_id, n_done, w, cnt;
    bit in_flight, inf_wr, prev_busy, prev_mv, grant_now, exp_grant;
    logic [AW-1:0] inf_addr;
    logic [DW-1:0] inf_wd, prev_rd, exp_rd;

    tbl[0]  = '{4'b0001, 1'b1, 0, 16'h0000};
    tbl[1]  = '{4'b0001, 1'b0, 0, 16'h0100};
    tbl[2]  = '{4'b1001, 1'b1, 3, 16'h0100};
    tbl[3]  = '{4'b1001, 1'b0, 0, 16'h0100};
    tbl[4]  = '{4'b0110, 1'b1, 1, 16'h0100};
    tbl[5]  = '{4'b0110, 1'b1, 2, 16'h0100};
    tbl[6]  = '{4'b0011, 1'b0, 0, 16'h0100};
    tbl[7]  = '{4'b1000, 1'b0, 3, 16'h0303};
    tbl[8]  = '{4'b1111, 1'b0, 0, 16'h0100};
    tbl[9]  = '{4'b0100, 1'b0, 2, 16'h0602};
    tbl[10] = '{4'b0010, 1'b0, 1, 16'h0501};

    for (int i = 0; i < 64; i++) bfm_mem[i] = '0;
    for (int k = 0; k < N; k++) begin
      a[k]  = '0;
      wd[k] = '0;
    end

    // Reset state
    rst_i = 1'b1;
    cycle();
    cycle();
    check("rst_mem_valid", 32'(mem_valid_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_ready", 32'(req_ready_o), 32'd0);
    check("rst_gnt_id", 32'(gnt_id_o), 32'd0);
    check("rst_rdata", 32'(req_rdata_o), 32'd0);
    check("rst_mem_addr", 32'(mem_addr_o), 32'd0);
    rst_i = 1'b0;
    cycle();

    // Rotation vectors from ptr=0
    bfm_lat = 0;
    for (int i = 0; i < 11; i++) run_entry(tbl[i], i);

    // Single read: one-cycle request latency, data returned
    bfm_mem[5] = 16'hA5A5;
    a[0] = 6'h05; wr = '0; v = 4'b0001;
    cycle();
    check("rd_latency_valid", 32'(mem_valid_o), 32'd1);
    check("rd_mem_addr", 32'(mem_addr_o), 32'h05);
    check("rd_gnt_id", 32'(gnt_id_o), 32'd0);
    wait_ready("rd", 20);
    check("rd_ready", 32'(req_ready_o), 32'b0001);
    check("rd_rdata", 32'(req_rdata_o), 32'hA5A5);
    v = '0;
    cycle();

    // Write then read-back; write completion leaves rdata untouched
    a[2] = 6'h3F; wd[2] = 16'h1234; wr = 4'b0100; v = 4'b0100;
    wait_ready("wr3f", 20);
    check("wr3f_ready", 32'(req_ready_o), 32'b0100);
    check("wr3f_rdata_hold", 32'(req_rdata_o), 32'hA5A5);
    v = '0;
    cycle();
    a[1] = 6'h3F; wr = '0; v = 4'b0010;
    wait_ready("rd3f", 20);
    check("rd3f_ready", 32'(req_ready_o), 32'b0010);
    check("rd3f_rdata", 32'(req_rdata_o), 32'h1234);
    v = '0;
    cycle();

    // All four writing continuously: strict rotation
    do_reset();
    bfm_lat = 1;
    wr = '1;
    for (int k = 0; k < N; k++) begin
      a[k] = 6'(k); wd[k] = 16'(k);
    end
    v = '1;
    for (int g = 0; g < 8; g++) begin
      wait_ready("rot", 20);
      check("rot_ready", 32'(req_ready_o), 32'(1 << (g % N)));
      wd[g % N] = 16'(g + 100);
    end
    v = '0;
    cycle();

    // Fields changed while BUSY are ignored; memory stalls
    bfm_lat = 5;
    a[3] = 6'h10; wr = '0; v = 4'b1000;
    cycle();
    check("stall_addr_first", 32'(mem_addr_o), 32'h10);
    a[3] = 6'h20;
    cnt = 0;
    for (int c = 0; c < 20 && req_ready_o == '0; c++) begin
      cycle();
      if (req_ready_o == '0) begin
        check("stall_valid_held", 32'(mem_valid_o), 32'd1);
        check("stall_addr_held", 32'(mem_addr_o), 32'h10);
        cnt++;
      end
    end
    check("stall_len", 32'(cnt), 32'd5);
    check("stall_ready", 32'(req_ready_o), 32'b1000);
    v = '0;
    cycle();

    // mem_ready_i outside BUSY has no effect
    bfm_lat = 0;
    bfm_force_ready = 1;
    cycle();
    cycle();
    check("idle_ready_busy", 32'(busy_o), 32'd0);
    check("idle_ready_pulse", 32'(req_ready_o), 32'd0);
    bfm_force_ready = 0;

    // Reset mid-transaction abandons it and rewinds the pointer
    a[0] = 6'h01; v = 4'b0001;
    wait_ready("pre_rst", 20);
    v = '0;
    cycle();
    bfm_lat = 8;
    a[2] = 6'h02; v = 4'b0100;
    cycle();
    cycle();
    check("mid_busy", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
    check("mid_rst_mem_valid", 32'(mem_valid_o), 32'd0);
    check("mid_rst_ready", 32'(req_ready_o), 32'd0);
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    bfm_lat = 0;
    v = 4'b0101;
    cnt = 0;
    for (int c = 0; c < 10 && !mem_valid_o; c++) begin
      cycle();
      cnt += (req_ready_o != '0) ? 1 : 0;
    end
    check("mid_rst_no_pulse", 32'(cnt), 32'd0);
    check("mid_rst_gnt", 32'(gnt_id_o), 32'd0);
    wait_ready("post_rst", 20);
    v = '0;
    cycle();

`ifdef MEM_ARB_TIMEOUT_EN
    // Watchdog: memory never answers
    bfm_stall = 1;
    v = 4'b0001; wr = '0;
    cycle();
    cnt = mem_valid_o ? 1 : 0;
    for (int c = 0; c < 40 && !timeout_o; c++) begin
      cycle();
      if (!timeout_o && mem_valid_o) cnt++;
    end
    check("to_pulse", 32'(timeout_o), 32'd1);
    check("to_busy_cycles", 32'(cnt), 32'd16);
    check("to_ready", 32'(req_ready_o), 32'b0001);
    check("to_rdata", 32'(req_rdata_o), 32'd0);
    v = '0;
    cycle();
    check("to_pulse_end", 32'(timeout_o), 32'd0);
    check("to_idle", 32'(busy_o), 32'd0);
    bfm_stall = 0;
`endif

    // Randomized run against the transaction-level model
    do_reset();
    ref_mem   = bfm_mem;
    ref_ptr   = 0;
    in_flight = 0;
    inf_id    = 0;
    inf_wr    = 0;
    inf_addr  = '0;
    inf_wd    = '0;
    n_done    = 0;
    prev_busy = busy_o;
    prev_mv   = mem_valid_o;
    prev_rd   = req_rdata_o;
    for (int c = 0; c < 1500; c++) begin
      cycle();
      grant_now = mem_valid_o && !prev_mv;
      exp_grant = !prev_busy && (v != '0);
      check("rand_grant_event", 32'(grant_now), 32'(exp_grant));
      if (grant_now && exp_grant) begin
        w = rr_ref(v, ref_ptr);
        check("rand_gnt_id", 32'(gnt_id_o), 32'(w));
        check("rand_mem_addr", 32'(mem_addr_o), 32'(a[w]));
        check("rand_mem_wr_rd", 32'(mem_wr_rd_o), 32'(wr[w]));
        if (wr[w]) check("rand_mem_wdata", 32'(mem_wdata_o), 32'(wd[w]));
        in_flight = 1;
        inf_id    = w;
        inf_wr    = wr[w];
        inf_addr  = a[w];
        inf_wd    = wd[w];
      end
      if (req_ready_o != '0) begin
        check("rand_ready", 32'(req_ready_o), in_flight ? 32'(1 << inf_id) : 32'd0);
        if (in_flight) begin
          if (inf_wr) begin
            ref_mem[inf_addr] = inf_wd;
            exp_rd = prev_rd;
          end else begin
            exp_rd = ref_mem[inf_addr];
          end
          check("rand_rdata", 32'(req_rdata_o), 32'(exp_rd));
          ref_ptr   = (inf_id + 1) % N;
          in_flight = 0;
          n_done++;
        end
      end
      for (int k = 0; k < N; k++) begin
        if (req_ready_o[k]) begin
          new_req(k, 1'($urandom % 2));
        end else if (in_flight && k == inf_id) begin
          if ($urandom % 4 == 0) new_req(k, 1'b1);
        end else if (v[k]) begin
          if ($urandom % 16 == 0) v[k] = 1'b0;
        end else if ($urandom % 3 == 0) begin
          new_req(k, 1'b1);
        end
      end
      prev_busy = busy_o;
      prev_mv   = mem_valid_o;
      prev_rd   = req_rdata_o;
      bfm_lat   = int'($urandom % 4);
    end
    check("rand_progress", 32'(n_done >= 100), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
- Round-robin arbiter that shares one single-port memory between NUM_REQ requesters.
- Each requester presents a valid-qualified read or write. The arbiter latches one request, drives the memory's valid/ready handshake, captures read data and returns a one-cycle completion to the winner.
- Sits between client blocks and the memory; its memory-side port matches the memory's clk_i/rst_i/valid/ready/wr_rd interface.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_WIDTH, 6, memory address width
- DATA_WIDTH, 16, memory data width
- TIMEOUT_CYC, 16, watchdog limit in cycles (used only with the optional feature)

Ports:
- clk_i  in  1  single clock, all logic on posedge
- rst_i  in  1  synchronous, active-high reset
- req_valid_i  in  NUM_REQ  per-requester request valid
- req_wr_rd_i  in  NUM_REQ  per-requester 1=write, 0=read
- req_addr_i  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata_i  in  NUM_REQ*DATA_WIDTH  packed write data, same packing
- req_ready_o  out  NUM_REQ  one-hot completion pulse
- req_rdata_o  out  DATA_WIDTH  read data, valid while req_ready_o pulses for a read
- gnt_id_o  out  $clog2(NUM_REQ)  index of current or last grantee
- busy_o  out  1  high in BUSY and DONE
- mem_valid_o, mem_wr_rd_o  out  1  memory request
- mem_addr_o  out  ADDR_WIDTH
- mem_wdata_o  out  DATA_WIDTH
- mem_rdata_i  in  DATA_WIDTH
- mem_ready_i  in  1  memory completion

Behaviour:
- Reset (rst_i=1 at posedge) has priority over everything:
  - All outputs become 0, state=IDLE, rotation pointer ptr=0.
  - Applies mid-transaction: the transaction is abandoned and no req_ready_o pulse is produced.
- FSM has three states: IDLE, BUSY, DONE.
- IDLE, when any req_valid_i is high:
  - Winner g = first set bit scanning ptr, ptr+1, … NUM_REQ-1, 0, … (wrap).
  - Latch g's wr_rd/addr/wdata into mem_*_o, set mem_valid_o=1 and gnt_id_o=g, go to BUSY.
  - Latency: mem_valid_o rises 1 cycle after req_valid_i.
- BUSY:
  - mem_valid_o and all mem_*_o are held stable.
  - When mem_ready_i=1: clear mem_valid_o. For a read, register mem_rdata_i into req_rdata_o; for a write, req_rdata_o is unchanged. Go to DONE.
- DONE:
  - req_ready_o[g]=1 for exactly one cycle; ptr <= (g+1) mod NUM_REQ; go to IDLE.
  - Minimum request-to-completion time is 3 cycles plus memory wait. There is one IDLE bubble between back-to-back grants.
- Requester rules:
  - Hold valid and fields until req_ready_o.
  - Dropping valid before being selected withdraws the request.
  - Changes after selection are ignored because the fields are latched.
- req_valid_i[g] still high in DONE is treated as a new request. It loses to other pending requesters due to rotation.
- mem_ready_i while not in BUSY is ignored.
- With a single requester continuously valid, it is granted every 3+ cycles; no starvation for any requester.

Optional Feature:
- MEM_ARB_TIMEOUT_EN defined:
  - A cycle counter runs in BUSY, cleared on entry.
  - If it reaches TIMEOUT_CYC without mem_ready_i: drop mem_valid_o, go to DONE, pulse req_ready_o[g], drive req_rdata_o=0, and pulse the extra output port timeout_o (1 bit) for one cycle.
- Undefined: timeout_o and the counter are absent; BUSY waits indefinitely.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_t
  - default width constants
- Sub-module rr_pick: combinational rotating priority picker.
  - Inputs: req vector, ptr.
  - Outputs: any_o, idx_o.
- Top module holds the FSM, data latches and watchdog.

Test Plan:
- Reset, then single read: req_valid_i=4'b0001, addr 6'h05, memory returns 16'hA5A5 → mem_valid_o high 1 cycle later; req_ready_o=4'b0001 with req_rdata_o=16'hA5A5; gnt_id_o=0.
- All four requesters writing continuously, memory ready 1 cycle after valid → grant order 0,1,2,3,0; each req_ready_o one-hot; no requester granted twice within any four grants.
- Write addr 6'h3F data 16'h1234 from requester 2, then read the same address from requester 1 → read returns 16'h1234; req_rdata_o unchanged during the write completion.
- Requester 3 changes addr from 6'h10 to 6'h20 while BUSY, memory stalls 5 cycles → mem_addr_o stays 6'h10 and mem_valid_o stays high throughout.
- rst_i asserted in BUSY → next cycle mem_valid_o=0, req_ready_o=0, busy_o=0; next grant starts from requester 0.
- MEM_ARB_TIMEOUT_EN defined, mem_ready_i tied 0 → after 16 BUSY cycles timeout_o pulses, req_ready_o[g] pulses, req_rdata_o=0, FSM returns to IDLE.
